// File: rtl/cbus_arbiter_n.sv
// N-port arbiter for the burst cache bus. One upstream master at a time is
// connected straight through to the single downstream port. A grant is held
// for the whole burst. It is released when the last beat completes or when
// the granted master withdraws its request.

package cbus_pkg;

    // Burst length encoding: number of beats minus one.
    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN2  = 8'd1;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // 151 bits
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    // 66 bits
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// State table
//   state | meaning
//   IDLE  | no grant held, downstream idle, arbitrate among valid requests
//   GRANT | grant_idx owns the downstream port until last beat or withdrawal
module cbus_arbiter_n
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS),
    parameter bit RR_MODE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  cbus_req_t            ireqs  [NUM_PORTS],
    output cbus_resp_t           iresps [NUM_PORTS],
    output cbus_req_t            oreq,
    input  cbus_resp_t           oresp,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [7:0]           beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] grant_d;
    logic [7:0]       beat_d;
    logic [IDX_W-1:0] last_idx, last_d;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    int               cand;

    // Registered state; last_idx resets to the top port so port 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            beat_cnt  <= '0;
            last_idx  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state     <= state_d;
            grant_idx <= grant_d;
            beat_cnt  <= beat_d;
            last_idx  <= last_d;
        end
    end

    // Winner selection: round-robin from the port after last_idx with a
    // modulo wrap (correct for non-power-of-2 port counts), or lowest index.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = 0;
        if (RR_MODE) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = (int'(last_idx) + k) % NUM_PORTS;
                if (!any_valid && ireqs[IDX_W'(cand)].valid) begin
                    any_valid = 1'b1;
                    winner    = IDX_W'(cand);
                end
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (ireqs[i].valid) begin
                    any_valid = 1'b1;
                    winner    = IDX_W'(i);
                end
            end
        end
    end

    // Next-state: grant on any request; release on last beat or withdrawal.
    // A completing beat takes precedence over a same-cycle valid drop.
    always_comb begin
        state_d = state;
        grant_d = grant_idx;
        beat_d  = beat_cnt;
        last_d  = last_idx;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    grant_d = winner;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                    last_d  = grant_idx;
                    beat_d  = '0;
                end else if (!ireqs[grant_idx].valid) begin
                    state_d = IDLE;
                    last_d  = grant_idx;
                    beat_d  = '0;
                end else if (oresp.ready && (beat_cnt != 8'hff)) begin
                    beat_d = beat_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: straight pass-through for the granted port only; everything
    // else is held at zero so no other master ever sees ready. Forced quiet
    // while reset is asserted, since the state register has not cleared yet.
    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            iresps[j] = '0;
        end
        if (!reset && (state == GRANT)) begin
            oreq              = ireqs[grant_idx];
            iresps[grant_idx] = oresp;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Directed bench for cbus_arbiter_n: four instances (2-port RR, 3-port fixed
// priority, 3-port RR, 5-port RR), exercised one after another.

module tb_cbus_arbiter_n;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u2: NUM_PORTS=2, round-robin
    cbus_req_t  req2 [2];
    cbus_resp_t rsp2 [2];
    cbus_req_t  oreq2;
    cbus_resp_t oresp2;
    logic       busy2;
    logic [0:0] gi2;
    logic [7:0] bc2;

    // u3f: NUM_PORTS=3, fixed priority
    cbus_req_t  req3f [3];
    cbus_resp_t rsp3f [3];
    cbus_req_t  oreq3f;
    cbus_resp_t oresp3f;
    logic       busy3f;
    logic [1:0] gi3f;
    logic [7:0] bc3f;

    // u3r: NUM_PORTS=3, round-robin
    cbus_req_t  req3r [3];
    cbus_resp_t rsp3r [3];
    cbus_req_t  oreq3r;
    cbus_resp_t oresp3r;
    logic       busy3r;
    logic [1:0] gi3r;
    logic [7:0] bc3r;

    // u5: NUM_PORTS=5, round-robin
    cbus_req_t  req5 [5];
    cbus_resp_t rsp5 [5];
    cbus_req_t  oreq5;
    cbus_resp_t oresp5;
    logic       busy5;
    logic [2:0] gi5;
    logic [7:0] bc5;

    cbus_arbiter_n #(.NUM_PORTS(2), .RR_MODE(1'b1)) u2 (
        .clk(clk), .reset(reset), .ireqs(req2), .iresps(rsp2),
        .oreq(oreq2), .oresp(oresp2), .busy(busy2), .grant_idx(gi2), .beat_cnt(bc2));

    cbus_arbiter_n #(.NUM_PORTS(3), .RR_MODE(1'b0)) u3f (
        .clk(clk), .reset(reset), .ireqs(req3f), .iresps(rsp3f),
        .oreq(oreq3f), .oresp(oresp3f), .busy(busy3f), .grant_idx(gi3f), .beat_cnt(bc3f));

    cbus_arbiter_n #(.NUM_PORTS(3), .RR_MODE(1'b1)) u3r (
        .clk(clk), .reset(reset), .ireqs(req3r), .iresps(rsp3r),
        .oreq(oreq3r), .oresp(oresp3r), .busy(busy3r), .grant_idx(gi3r), .beat_cnt(bc3r));

    cbus_arbiter_n #(.NUM_PORTS(5), .RR_MODE(1'b1)) u5 (
        .clk(clk), .reset(reset), .ireqs(req5), .iresps(rsp5),
        .oreq(oreq5), .oresp(oresp5), .busy(busy5), .grant_idx(gi5), .beat_cnt(bc5));

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic wr, input logic [63:0] addr,
                                         input logic [63:0] data, input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.addr     = addr;
        r.strobe   = wr ? 8'hff : 8'h00;
        r.data     = data;
        r.len      = len;
        r.burst    = BURST_INCR;
        return r;
    endfunction

    function automatic cbus_resp_t mk_rsp(input logic rdy, input logic lst, input logic [63:0] data);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = data;
        return r;
    endfunction

    cbus_req_t  exp_req;
    cbus_resp_t exp_rsp;
    int         g;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) req2[i]  = '0;
        for (int i = 0; i < 3; i++) req3f[i] = '0;
        for (int i = 0; i < 3; i++) req3r[i] = '0;
        for (int i = 0; i < 5; i++) req5[i]  = '0;
        oresp2 = '0; oresp3f = '0; oresp3r = '0; oresp5 = '0;
        reset  = 1'b1;
        tick();
        tick();
        // Requests during reset must not leak downstream.
        req2[0] = mk_req(1'b0, 64'h1000, 64'h0, MLEN4);
        #1;
        check_eq("rst_oreq_valid", 192'(oreq2.valid), 192'(0));
        check_eq("rst_busy", 192'(busy2), 192'(0));
        check_eq("rst_grant_idx", 192'(gi2), 192'(0));
        check_eq("rst_beat_cnt", 192'(bc2), 192'(0));
        check_eq("rst_iresp0", 192'(rsp2[0]), 192'(0));
        req2[0] = '0;
        tick();
        reset = 1'b0;

        // ---- fixed priority, 3 ports: port 1 beats port 2 every time ----
        req3f[1] = mk_req(1'b0, 64'h11, 64'h0, MLEN1);
        req3f[2] = mk_req(1'b0, 64'h22, 64'h0, MLEN1);
        #1;
        check_eq("fp_idle_oreq_valid", 192'(oreq3f.valid), 192'(0));
        for (int t = 0; t < 3; t++) begin
            tick();
            check_eq("fp_busy", 192'(busy3f), 192'(1));
            check_eq("fp_grant_p1", 192'(gi3f), 192'(1));
            check_eq("fp_oreq_addr", 192'(oreq3f.addr), 192'(64'h11));
            if (t == 2) req3f[0] = mk_req(1'b0, 64'h00, 64'h0, MLEN1);
            oresp3f = mk_rsp(1'b1, 1'b1, 64'h5a);
            #1;
            check_eq("fp_rsp1_ready", 192'(rsp3f[1].ready), 192'(1));
            check_eq("fp_rsp2_quiet", 192'(rsp3f[2]), 192'(0));
            tick();
            oresp3f = '0;
            #1;
            check_eq("fp_idle_busy", 192'(busy3f), 192'(0));
            check_eq("fp_idle_gap_valid", 192'(oreq3f.valid), 192'(0));
        end
        tick();
        check_eq("fp_late_p0_wins", 192'(gi3f), 192'(0));
        oresp3f = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) req3f[i] = '0;
        oresp3f = '0;
        tick();

        // ---- round-robin, 3 ports: lone write on port 2 ----
        exp_req  = mk_req(1'b1, 64'h8000_0040, 64'hdead_beef, MLEN1);
        req3r[2] = exp_req;
        #1;
        check_eq("rr3_t_oreq_valid", 192'(oreq3r.valid), 192'(0));
        tick();
        check_eq("rr3_oreq_passthru", 192'(oreq3r), 192'(exp_req));
        exp_rsp = mk_rsp(1'b1, 1'b1, 64'h0123_4567_89ab_cdef);
        oresp3r = exp_rsp;
        #1;
        check_eq("rr3_rsp2", 192'(rsp3r[2]), 192'(exp_rsp));
        check_eq("rr3_rsp0_quiet", 192'(rsp3r[0]), 192'(0));
        check_eq("rr3_rsp1_quiet", 192'(rsp3r[1]), 192'(0));
        tick();
        oresp3r  = '0;
        req3r[2] = '0;
        #1;
        check_eq("rr3_done_busy", 192'(busy3r), 192'(0));
        for (int i = 0; i < 3; i++) req3r[i] = mk_req(1'b0, 64'(i), 64'h0, MLEN1);
        tick();
        check_eq("rr3_wrap_to_p0", 192'(gi3r), 192'(0));
        oresp3r = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        oresp3r = '0;
        #1;
        check_eq("rr3_idle_busy", 192'(busy3r), 192'(0));
        tick();
        check_eq("rr3_next_p1", 192'(gi3r), 192'(1));
        oresp3r = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) req3r[i] = '0;
        oresp3r = '0;
        tick();

        // ---- round-robin, 5 ports: saturation on port 4, then wrap ----
        req5[4] = mk_req(1'b0, 64'h44, 64'h0, 8'hff);
        tick();
        check_eq("rr5_grant_p4", 192'(gi5), 192'(4));
        oresp5 = mk_rsp(1'b1, 1'b0, 64'h0);
        for (int b = 0; b < 260; b++) tick();
        check_eq("rr5_beat_saturate", 192'(bc5), 192'(8'hff));
        oresp5 = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        oresp5  = '0;
        req5[4] = '0;
        req5[0] = mk_req(1'b0, 64'h00, 64'h0, MLEN1);
        req5[3] = mk_req(1'b0, 64'h33, 64'h0, MLEN1);
        #1;
        check_eq("rr5_done_busy", 192'(busy5), 192'(0));
        check_eq("rr5_done_beat", 192'(bc5), 192'(0));
        tick();
        check_eq("rr5_wrap_p0", 192'(gi5), 192'(0));
        oresp5 = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        oresp5 = '0;
        tick();
        check_eq("rr5_then_p3", 192'(gi5), 192'(3));
        oresp5 = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        for (int i = 0; i < 5; i++) req5[i] = '0;
        oresp5 = '0;
        tick();

        // ---- round-robin, 2 ports: alternating 4-beat reads ----
        req2[0] = mk_req(1'b0, 64'h1000, 64'h0, MLEN4);
        req2[1] = mk_req(1'b0, 64'h2000, 64'h0, MLEN4);
        #1;
        check_eq("rr2_c1_oreq_valid", 192'(oreq2.valid), 192'(0));
        for (int t = 0; t < 6; t++) begin
            g = t % 2;
            tick();
            check_eq("rr2_busy", 192'(busy2), 192'(1));
            check_eq("rr2_alternate", 192'(gi2), 192'(g));
            check_eq("rr2_oreq_addr", 192'(oreq2.addr), 192'((g == 1) ? 64'h2000 : 64'h1000));
            for (int b = 0; b < 4; b++) begin
                oresp2 = mk_rsp(1'b1, (b == 3), 64'(b));
                #1;
                check_eq("rr2_rsp_granted", 192'(rsp2[g].ready), 192'(1));
                check_eq("rr2_rsp_other", 192'(rsp2[1-g]), 192'(0));
                if (b == 3) check_eq("rr2_beat_cnt3", 192'(bc2), 192'(3));
                tick();
            end
            oresp2 = '0;
            #1;
            check_eq("rr2_gap_busy", 192'(busy2), 192'(0));
            check_eq("rr2_gap_valid", 192'(oreq2.valid), 192'(0));
        end

        // ---- abort: port 0 withdraws after 5 of 16 beats ----
        req2[0].len = MLEN16;
        tick();
        check_eq("abort_grant_p0", 192'(gi2), 192'(0));
        oresp2 = mk_rsp(1'b1, 1'b0, 64'h0);
        for (int b = 0; b < 5; b++) tick();
        oresp2        = '0;
        req2[0].valid = 1'b0;
        #1;
        check_eq("abort_beat5", 192'(bc2), 192'(5));
        check_eq("abort_oreq_follows", 192'(oreq2.valid), 192'(0));
        tick();
        check_eq("abort_busy", 192'(busy2), 192'(0));
        check_eq("abort_beat_clr", 192'(bc2), 192'(0));
        tick();
        check_eq("abort_p1_busy", 192'(busy2), 192'(1));
        check_eq("abort_p1_grant", 192'(gi2), 192'(1));

        // ---- synchronous reset in the middle of port 1's burst ----
        oresp2 = mk_rsp(1'b1, 1'b0, 64'h0);
        tick();
        tick();
        oresp2        = '0;
        req2[0].valid = 1'b1;
        reset         = 1'b1;
        #1;
        check_eq("mrst_oreq_quiet", 192'(oreq2.valid), 192'(0));
        tick();
        reset = 1'b0;
        #1;
        check_eq("mrst_busy", 192'(busy2), 192'(0));
        check_eq("mrst_oreq_valid", 192'(oreq2.valid), 192'(0));
        check_eq("mrst_grant_idx", 192'(gi2), 192'(0));
        check_eq("mrst_beat_cnt", 192'(bc2), 192'(0));
        tick();
        check_eq("mrst_first_p0", 192'(gi2), 192'(0));
        check_eq("mrst_first_busy", 192'(busy2), 192'(1));
        oresp2 = mk_rsp(1'b1, 1'b1, 64'h0);
        tick();
        req2[0] = '0;
        req2[1] = '0;
        oresp2  = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
